// File: rtl/pueo_evbuf_pkg.sv
// Shared constants for the PUEO DDR4 event buffer tracker.
package pueo_evbuf_pkg;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_REL   = 2'd1;
  localparam logic [1:0] ERR_CMPL  = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  localparam int unsigned CMPL_IDX_LSB = 0;
  localparam int unsigned CMPL_IDX_W   = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } evbuf_state_t;

endpackage

// File: rtl/pueo_evbuf_free_fifo.sv
// Free-index FIFO with a registered head; a push into an empty FIFO bypasses
// straight into the head register so it is visible the following cycle.
module pueo_evbuf_free_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = $clog2(DEPTH)
) (
  input  logic         memclk,
  input  logic         memrst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic [W:0]   count
);

  localparam int unsigned CW = W + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  wr_ptr_q;
  logic [W-1:0]  rd_ptr_q;
  logic [CW-1:0] mem_cnt_q;
  logic [W-1:0]  dout_q;
  logic          valid_q;
  logic          load_out;
  logic          mem_rd;
  logic          mem_wr;
  logic          bypass;

  always_comb begin
    load_out = !valid_q || pop;
    mem_rd   = load_out && (mem_cnt_q != '0);
    bypass   = load_out && (mem_cnt_q == '0) && push;
    mem_wr   = push && !bypass;
  end

  always_ff @(posedge memclk) begin
    if (memrst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr_q <= wr_ptr_q + W'(1);
      if (mem_rd) rd_ptr_q <= rd_ptr_q + W'(1);
      if (mem_wr && !mem_rd)      mem_cnt_q <= mem_cnt_q + CW'(1);
      else if (!mem_wr && mem_rd) mem_cnt_q <= mem_cnt_q - CW'(1);
      if (mem_rd) begin
        dout_q  <= mem[rd_ptr_q];
        valid_q <= 1'b1;
      end else if (bypass) begin
        dout_q  <= din;
        valid_q <= 1'b1;
      end else if (load_out) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge memclk) begin
    if (mem_wr) mem[wr_ptr_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign count      = mem_cnt_q + CW'(valid_q);

endmodule

// File: rtl/pueo_event_buffer_tracker.sv
// Owns the DDR4 event buffer index pool: issues free indices, forwards
// completions to readout, reclaims released indices and flags protocol errors.
module pueo_event_buffer_tracker
  import pueo_evbuf_pkg::*;
#(
  parameter int unsigned NBUF = 16,
  parameter int unsigned IDXW = $clog2(NBUF)
) (
  input  logic            memclk,
  input  logic            memrst,
  output logic [15:0]     m_done_tdata,
  output logic            m_done_tvalid,
  input  logic            m_done_tready,
  input  logic [63:0]     s_cmpl_tdata,
  input  logic            s_cmpl_tvalid,
  output logic            s_cmpl_tready,
  output logic [63:0]     m_evt_tdata,
  output logic            m_evt_tvalid,
  input  logic            m_evt_tready,
  input  logic [15:0]     s_release_tdata,
  input  logic            s_release_tvalid,
  output logic            s_release_tready,
  output logic [IDXW:0]   free_count_o,
  output logic [IDXW:0]   busy_count_o,
  output logic            init_done_o,
  output logic            err_o,
  output logic [1:0]      err_code_o
);

  localparam int unsigned CNTW = IDXW + 1;

  evbuf_state_t          state_q;
  evbuf_state_t          state_d;
  logic [IDXW-1:0]       init_idx_q;
  logic [NBUF-1:0]       in_use_q;
  logic [NBUF-1:0]       in_use_d;
  logic [CNTW-1:0]       busy_q;
  logic [CNTW-1:0]       busy_d;
  logic                  run_q;
  logic                  live_q;
  logic                  err_q;
  logic [1:0]            err_code_q;
  logic                  evt_valid_q;
  logic [63:0]           evt_data_q;

  logic                  fifo_push;
  logic [IDXW-1:0]       fifo_din;
  logic [IDXW-1:0]       fifo_dout;
  logic                  fifo_valid;
  logic                  done_pop;
  logic [CMPL_IDX_W-1:0] cmpl_raw;
  logic [IDXW-1:0]       rel_idx;
  logic [IDXW-1:0]       cmpl_idx;
  logic                  rel_oor;
  logic                  cmpl_oor;
  logic                  rel_hs;
  logic                  rel_ok;
  logic                  cmpl_hs;
  logic                  err_set;
  logic [1:0]            err_new;

  // Index decode: anything above the low IDXW bits means out of range.
  assign cmpl_raw = s_cmpl_tdata[CMPL_IDX_LSB +: CMPL_IDX_W];
  assign rel_idx  = s_release_tdata[IDXW-1:0];
  assign cmpl_idx = cmpl_raw[IDXW-1:0];
  assign rel_oor  = |s_release_tdata[15:IDXW];
  assign cmpl_oor = |cmpl_raw[CMPL_IDX_W-1:IDXW];

  assign s_cmpl_tready = live_q && (!evt_valid_q || m_evt_tready);
  assign cmpl_hs       = s_cmpl_tvalid && s_cmpl_tready;
  assign done_pop      = fifo_valid && m_done_tready;
  assign rel_hs        = s_release_tvalid && run_q;
  assign rel_ok        = rel_hs && !rel_oor && in_use_q[rel_idx];

  always_ff @(posedge memclk) begin
    if (memrst) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    fifo_din  = rel_idx;
    case (state_q)
      ST_INIT: begin
        fifo_push = 1'b1;
        fifo_din  = init_idx_q;
        if (init_idx_q == IDXW'(NBUF - 1)) state_d = ST_RUN;
      end
      ST_RUN: fifo_push = rel_ok;
    endcase
  end

  // Release errors take precedence over completion errors in the same cycle.
  always_comb begin
    err_set = 1'b0;
    err_new = ERR_NONE;
    if (rel_hs && rel_oor) begin
      err_set = 1'b1;
      err_new = ERR_RANGE;
    end else if (rel_hs && !in_use_q[rel_idx]) begin
      err_set = 1'b1;
      err_new = ERR_REL;
    end else if (cmpl_hs && cmpl_oor) begin
      err_set = 1'b1;
      err_new = ERR_RANGE;
    end else if (cmpl_hs && !in_use_q[cmpl_idx]) begin
      err_set = 1'b1;
      err_new = ERR_CMPL;
    end
  end

  always_comb begin
    in_use_d = in_use_q;
    if (done_pop) in_use_d[fifo_dout] = 1'b1;
    if (rel_ok)   in_use_d[rel_idx]   = 1'b0;
    busy_d = busy_q;
    if (done_pop && !rel_ok)      busy_d = busy_q + CNTW'(1);
    else if (!done_pop && rel_ok) busy_d = busy_q - CNTW'(1);
  end

  always_ff @(posedge memclk) begin
    if (memrst) begin
      init_idx_q  <= '0;
      in_use_q    <= '0;
      busy_q      <= '0;
      run_q       <= 1'b0;
      live_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
    end else begin
      live_q   <= 1'b1;
      run_q    <= (state_d == ST_RUN);
      in_use_q <= in_use_d;
      busy_q   <= busy_d;
      if (state_q == ST_INIT) init_idx_q <= init_idx_q + IDXW'(1);
      if (err_set && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= err_new;
      end
      if (cmpl_hs) begin
        evt_valid_q <= 1'b1;
        evt_data_q  <= s_cmpl_tdata;
      end else if (m_evt_tready) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  pueo_evbuf_free_fifo #(
    .DEPTH (NBUF),
    .W     (IDXW)
  ) u_free_fifo (
    .memclk     (memclk),
    .memrst     (memrst),
    .push       (fifo_push),
    .din        (fifo_din),
    .pop        (done_pop),
    .dout       (fifo_dout),
    .dout_valid (fifo_valid),
    .count      (free_count_o)
  );

  assign m_done_tdata     = 16'(fifo_dout);
  assign m_done_tvalid    = fifo_valid;
  assign m_evt_tdata      = evt_data_q;
  assign m_evt_tvalid     = evt_valid_q;
  assign s_release_tready = run_q;
  assign busy_count_o     = busy_q;
  assign init_done_o      = run_q;
  assign err_o            = err_q;
  assign err_code_o       = err_code_q;

endmodule

// File: tb/tb_pueo_event_buffer_tracker.sv
// Bench for pueo_event_buffer_tracker: queue-based pool model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pueo_event_buffer_tracker;

  localparam int unsigned NBUF = 16;
  localparam int unsigned IDXW = 4;

  logic            memclk = 1'b0;
  logic            memrst;
  logic [15:0]     m_done_tdata;
  logic            m_done_tvalid;
  logic            m_done_tready;
  logic [63:0]     s_cmpl_tdata;
  logic            s_cmpl_tvalid;
  logic            s_cmpl_tready;
  logic [63:0]     m_evt_tdata;
  logic            m_evt_tvalid;
  logic            m_evt_tready;
  logic [15:0]     s_release_tdata;
  logic            s_release_tvalid;
  logic            s_release_tready;
  logic [IDXW:0]   free_count_o;
  logic [IDXW:0]   busy_count_o;
  logic            init_done_o;
  logic            err_o;
  logic [1:0]      err_code_o;

  pueo_event_buffer_tracker #(.NBUF(NBUF), .IDXW(IDXW)) dut (
    .memclk           (memclk),
    .memrst           (memrst),
    .m_done_tdata     (m_done_tdata),
    .m_done_tvalid    (m_done_tvalid),
    .m_done_tready    (m_done_tready),
    .s_cmpl_tdata     (s_cmpl_tdata),
    .s_cmpl_tvalid    (s_cmpl_tvalid),
    .s_cmpl_tready    (s_cmpl_tready),
    .m_evt_tdata      (m_evt_tdata),
    .m_evt_tvalid     (m_evt_tvalid),
    .m_evt_tready     (m_evt_tready),
    .s_release_tdata  (s_release_tdata),
    .s_release_tvalid (s_release_tvalid),
    .s_release_tready (s_release_tready),
    .free_count_o     (free_count_o),
    .busy_count_o     (busy_count_o),
    .init_done_o      (init_done_o),
    .err_o            (err_o),
    .err_code_o       (err_code_o)
  );

  always #5 memclk = ~memclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pool model: the free list is an ordered queue whose head is what m_done shows.
  int unsigned fq[$];
  bit          in_use_m [NBUF];
  int unsigned init_n;
  bit          running, live, started, m_err, evt_v;
  logic [1:0]  m_code;
  logic [63:0] evt_d;

  always @(posedge memclk) begin
    bit pop, rel_good, c_hs;
    int unsigned r, c, code;
    if (memrst) begin
      fq.delete();
      foreach (in_use_m[i]) in_use_m[i] = 1'b0;
      init_n  = 0;
      running = 1'b0;
      live    = 1'b0;
      evt_v   = 1'b0;
      evt_d   = '0;
      m_err   = 1'b0;
      m_code  = 2'd0;
      started = 1'b1;
    end else if (started) begin
      pop      = (fq.size() != 0) && m_done_tready;
      c_hs     = live && (!evt_v || m_evt_tready) && s_cmpl_tvalid;
      r        = 32'(s_release_tdata);
      c        = 32'(s_cmpl_tdata[15:0]);
      rel_good = 1'b0;
      code     = 0;
      if (running && s_release_tvalid) begin
        if (r >= NBUF)        code = 3;
        else if (!in_use_m[r]) code = 1;
        else                   rel_good = 1'b1;
      end
      if (code == 0 && c_hs) begin
        if (c >= NBUF)         code = 3;
        else if (!in_use_m[c]) code = 2;
      end
      if (!m_err && code != 0) begin
        m_err  = 1'b1;
        m_code = 2'(code);
      end
      if (pop) in_use_m[fq.pop_front()] = 1'b1;
      if (rel_good) begin
        in_use_m[r] = 1'b0;
        fq.push_back(r);
      end
      if (!running) begin
        fq.push_back(init_n);
        init_n++;
        if (init_n == NBUF) running = 1'b1;
      end
      if (c_hs) begin
        evt_v = 1'b1;
        evt_d = s_cmpl_tdata;
      end else if (m_evt_tready) begin
        evt_v = 1'b0;
      end
      live = 1'b1;
    end
  end

  logic [15:0] beats[$];
  logic [63:0] evts[$];

  always @(negedge memclk) begin
    int unsigned busy_m;
    if (started) begin
      busy_m = 0;
      foreach (in_use_m[i]) busy_m += 32'(in_use_m[i]);
      chk("m_done_tvalid", 64'(m_done_tvalid), 64'(fq.size() != 0));
      if (fq.size() != 0) chk("m_done_tdata", 64'(m_done_tdata), 64'(fq[0]));
      chk("free_count", 64'(free_count_o), 64'(fq.size()));
      chk("busy_count", 64'(busy_count_o), 64'(busy_m));
      chk("init_done", 64'(init_done_o), 64'(running));
      chk("s_release_tready", 64'(s_release_tready), 64'(running));
      chk("s_cmpl_tready", 64'(s_cmpl_tready), 64'(live && (!evt_v || m_evt_tready)));
      chk("m_evt_tvalid", 64'(m_evt_tvalid), 64'(evt_v));
      if (evt_v) chk("m_evt_tdata", m_evt_tdata, evt_d);
      chk("err", 64'(err_o), 64'(m_err));
      chk("err_code", 64'(err_code_o), 64'(m_code));
      if (running) chk("count_sum", 64'(free_count_o) + 64'(busy_count_o), 64'(NBUF));
      if (m_done_tvalid && m_done_tready) beats.push_back(m_done_tdata);
      if (m_evt_tvalid && m_evt_tready) evts.push_back(m_evt_tdata);
    end
  end

  task automatic tick();
    @(posedge memclk);
    #1;
  endtask

  task automatic release_idx(input logic [15:0] idx);
    s_release_tvalid = 1'b1;
    s_release_tdata  = idx;
    tick();
    s_release_tvalid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done_tvalid"}, 64'(m_done_tvalid), 64'd0);
    chk({tag, "_evt_tvalid"}, 64'(m_evt_tvalid), 64'd0);
    chk({tag, "_cmpl_tready"}, 64'(s_cmpl_tready), 64'd0);
    chk({tag, "_rel_tready"}, 64'(s_release_tready), 64'd0);
    chk({tag, "_free"}, 64'(free_count_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_count_o), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_err_code"}, 64'(err_code_o), 64'd0);
  endtask

  task automatic chk_full_sweep(input string tag);
    chk({tag, "_count"}, 64'(beats.size()), 64'(NBUF));
    if (beats.size() == NBUF)
      for (int i = 0; i < NBUF; i++) chk({tag, "_idx"}, 64'(beats[i]), 64'(i));
  endtask

  logic [63:0] d0, d1;
  int unsigned exp_b [3];

  initial begin
    memrst           = 1'b1;
    m_done_tready    = 1'b1;
    s_cmpl_tdata     = '0;
    s_cmpl_tvalid    = 1'b0;
    m_evt_tready     = 1'b1;
    s_release_tdata  = '0;
    s_release_tvalid = 1'b0;

    // Reset, then the whole pool streams out in index order.
    repeat (4) tick();
    chk_reset_state("rst0");
    memrst = 1'b0;
    beats.delete();
    tick();
    chk("first_done_valid", 64'(m_done_tvalid), 64'd1);
    chk("first_done_data", 64'(m_done_tdata), 64'd0);
    repeat (19) tick();
    chk_full_sweep("init_sweep");
    chk("drained_valid", 64'(m_done_tvalid), 64'd0);
    chk("drained_busy", 64'(busy_count_o), 64'd16);
    chk("drained_free", 64'(free_count_o), 64'd0);
    chk("drained_init_done", 64'(init_done_o), 64'd1);

    // Single release is reissued the next cycle.
    release_idx(16'd5);
    chk("rel5_busy", 64'(busy_count_o), 64'd15);
    chk("rel5_valid", 64'(m_done_tvalid), 64'd1);
    chk("rel5_data", 64'(m_done_tdata), 64'd5);
    tick();
    chk("reissue5_busy", 64'(busy_count_o), 64'd16);

    // Double release and out-of-range release: first error code sticks.
    m_done_tready = 1'b0;
    release_idx(16'd5);
    release_idx(16'd5);
    chk("dbl_err", 64'(err_o), 64'd1);
    chk("dbl_code", 64'(err_code_o), 64'd1);
    chk("dbl_free", 64'(free_count_o), 64'd1);
    release_idx(16'd20);
    chk("oor_code_kept", 64'(err_code_o), 64'd1);
    chk("oor_free", 64'(free_count_o), 64'd1);
    m_done_tready = 1'b1;
    tick();
    m_done_tready = 1'b0;

    // Backpressured releases, then a release concurrent with a pop.
    release_idx(16'd3);
    release_idx(16'd7);
    chk("bp_free", 64'(free_count_o), 64'd2);
    chk("bp_busy", 64'(busy_count_o), 64'd14);
    beats.delete();
    m_done_tready    = 1'b1;
    s_release_tvalid = 1'b1;
    s_release_tdata  = 16'd9;
    tick();
    s_release_tvalid = 1'b0;
    repeat (3) tick();
    exp_b = '{3, 7, 9};
    chk("order_count", 64'(beats.size()), 64'd3);
    if (beats.size() == 3)
      for (int i = 0; i < 3; i++) chk("order_idx", 64'(beats[i]), 64'(exp_b[i]));
    chk("order_busy", 64'(busy_count_o), 64'd16);

    // Completion slice under output backpressure.
    d0 = 64'hA5A5_1234_5678_0000;
    d1 = 64'h0BAD_CAFE_F00D_0001;
    evts.delete();
    s_cmpl_tvalid = 1'b1;
    s_cmpl_tdata  = d0;
    m_evt_tready  = 1'b1;
    tick();
    s_cmpl_tdata = d1;
    m_evt_tready = 1'b0;
    #1;
    chk("slice_full_tready", 64'(s_cmpl_tready), 64'd0);
    tick();
    m_evt_tready = 1'b1;
    #1;
    chk("slice_drain_tready", 64'(s_cmpl_tready), 64'd1);
    tick();
    s_cmpl_tvalid = 1'b0;
    repeat (2) tick();
    chk("evt_count", 64'(evts.size()), 64'd2);
    if (evts.size() == 2) begin
      chk("evt0", evts[0], d0);
      chk("evt1", evts[1], d1);
    end

    // Reset in the middle of INIT, then a clean re-initialisation.
    memrst = 1'b1;
    tick();
    chk_reset_state("rst1");
    memrst = 1'b0;
    repeat (6) tick();
    memrst = 1'b1;
    tick();
    chk_reset_state("rst2");
    memrst = 1'b0;
    beats.delete();
    repeat (20) tick();
    chk_full_sweep("reinit_sweep");
    chk("reinit_busy", 64'(busy_count_o), 64'd16);

    // Completion for an index that is not in use, then one out of range.
    m_done_tready = 1'b0;
    release_idx(16'd12);
    s_cmpl_tvalid = 1'b1;
    s_cmpl_tdata  = {48'hDEAD_BEEF_0001, 16'd12};
    tick();
    s_cmpl_tdata = {48'hDEAD_BEEF_0002, 16'd300};
    tick();
    s_cmpl_tvalid = 1'b0;
    tick();
    chk("cmpl_err", 64'(err_o), 64'd1);
    chk("cmpl_code", 64'(err_code_o), 64'd2);

    // Fresh pool left full, then an out-of-range release.
    memrst = 1'b1;
    tick();
    memrst = 1'b0;
    repeat (18) tick();
    chk("full_free", 64'(free_count_o), 64'd16);
    chk("full_busy", 64'(busy_count_o), 64'd0);
    chk("full_init_done", 64'(init_done_o), 64'd1);
    release_idx(16'd20);
    chk("range_err", 64'(err_o), 64'd1);
    chk("range_code", 64'(err_code_o), 64'd3);
    chk("range_free", 64'(free_count_o), 64'd16);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pueo_event_buffer_tracker.md
Name: pueo_event_buffer_tracker

Overview:
- Owns the pool of DDR4 event buffer indices used by pueo_turfio_event_req_gen.
- Issues free buffer indices on m_done (feeds req_gen s_done).
- Consumes req_gen completions on s_cmpl and forwards them to readout on m_evt.
- Accepts buffer releases from readout on s_release and returns those indices to the free pool. Detects protocol errors; one memclk domain.

Parameters:
- NBUF, 16, number of event buffers (power of 2, 2..256)
- IDXW, $clog2(NBUF), index width used internally

Ports:
- memclk  in  1  clock (DDR4 ui_clk)
- memrst  in  1  synchronous active-high reset
- m_done_tdata  out  16  free buffer index, zero-extended
- m_done_tvalid  out  1  AXI4-S valid
- m_done_tready  in  1  AXI4-S ready
- s_cmpl_tdata  in  64  completion; [15:0]=buffer index, [63:16]=event metadata
- s_cmpl_tvalid  in  1
- s_cmpl_tready  out  1
- m_evt_tdata  out  64  completion forwarded unchanged
- m_evt_tvalid  out  1
- m_evt_tready  in  1
- s_release_tdata  in  16  buffer index being returned
- s_release_tvalid  in  1
- s_release_tready  out  1
- free_count_o  out  IDXW+1  entries in free FIFO
- busy_count_o  out  IDXW+1  indices issued, not yet released
- init_done_o  out  1  free pool populated
- err_o  out  1  sticky protocol error
- err_code_o  out  2  code of first error: 1=bad release, 2=bad completion, 3=index out of range

Behaviour:
- Reset (memrst=1 at edge) puts outputs in this state:
  - m_done_tvalid=0, m_evt_tvalid=0
  - s_cmpl_tready=0, s_release_tready=0
  - free_count=0, busy_count=0
  - init_done=0, err=0, err_code=0
  - FIFO pointers and in_use bitmap cleared
- Reset asserted mid-operation discards all state and restarts INIT.
- States: INIT, RUN.
- INIT:
  - Writes index 0..NBUF-1 into the free FIFO, one per cycle starting the first cycle after reset deasserts.
  - s_release_tready=0 throughout INIT.
  - m_done may already pop written entries.
  - After writing NBUF-1, go to RUN; init_done=1 from the next cycle.
- Free FIFO: depth NBUF, registered output. The head is valid on m_done the cycle after its write (1-cycle latency).
- m_done handshake:
  - On valid&ready: pop the FIFO and set in_use[idx].
  - tdata stays stable while valid&!ready.
- s_release in RUN:
  - tready=1. Indices are range-checked.
  - Accepted index with in_use=1: clear bit, push to FIFO.
  - Index >= NBUF or in_use=0: drop, set err (code 3 or 1).
- Same-cycle push and pop: both occur; free_count unchanged. A push into an empty FIFO appears on m_done one cycle later.
- The FIFO cannot overflow, because the bitmap guarantees at most NBUF distinct entries.
- Same-cycle done-pop and release of the same index cannot occur: in_use is 0 before the pop.
- s_cmpl: 1-entry register slice.
  - s_cmpl_tready = !m_evt_tvalid || m_evt_tready (outside reset).
  - Data is forwarded unchanged with 1-cycle latency.
  - Completion index not in_use or >= NBUF: set err (code 2/3), but still forward.
- busy_count = popcount-equivalent counter: +1 on done pop, -1 on accepted release, both in same cycle = no change.
- Invariant: free_count + busy_count = NBUF in RUN.
- err_code latches on the first error only; cleared by reset alone.

Decomposition:
- Package pueo_evbuf_pkg: err code localparams (ERR_NONE, ERR_REL, ERR_CMPL, ERR_RANGE), cmpl field offsets (CMPL_IDX_LSB=0, CMPL_IDX_W=16).
- One sub-module: pueo_evbuf_free_fifo (sync FIFO, registered output, count output).

Test Plan:
- Reset 4 cycles, m_done_tready=1 → m_done emits 0,1,…,15 on consecutive cycles starting 2 cycles after reset release. Then tvalid=0, busy_count=16, free_count=0, init_done=1.
- After pool drained, release 5 → m_done emits 5 one cycle after the push. busy_count 16→15→16.
- Release 5 twice without reissue → second dropped, err=1, err_code=1, free_count unchanged. Release 20 (NBUF=16) → err stays at code 1 (first error latched).
- m_done_tready=0 while releasing 3 and 7 → free_count=2. Then ready=1 with simultaneous release of 9 → emits 3, 7, 9 in order; counts sum to 16 every cycle.
- s_cmpl stream {idx 0, idx 1} with m_evt_tready toggling 1,0,1 → both words delivered unchanged, no duplication. s_cmpl_tready low exactly while the slice is full and ready=0.
- Assert memrst at INIT cycle 6 → outputs return to reset values. Re-init re-emits from index 0, none of the old indices are lost or duplicated.
